// File: rtl/rv32i_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the RV32I front end: program-counter width, the
// default reset fetch address, the bubble instruction word, the fetch FSM
// state encoding and two small PC helpers used by the fetch stage.
// ----------------------------------------------------------------------------
package rv32i_pkg;

   localparam int PC_W = 20;

   // First fetch address after reset.
   localparam logic [PC_W-1:0] RESET_PC_DEF = 20'h00000;

   // Bubble word inserted into IF/ID on a flush: ADDI x0,x0,0.
   localparam logic [31:0] NOP_INSTR_DEF = 32'h00000013;

   // BOOT is the one-cycle warm-up after reset; RUN is steady-state fetch.
   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } fetch_state_e;

   // Sequential successor of a PC; wraps naturally at 2^PC_W.
   function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
      return pc + PC_W'(4);
   endfunction

   // Word-align a target address by clearing its two low bits. Misaligned
   // targets are silently aligned; no exception is ever raised.
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
      return pc & ~PC_W'(3);
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with load, flush and hold controls.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   load_i   in   capture pc_i/pc4_i/instr_i as a valid instruction
//   flush_i  in   replace the instruction by a bubble, keep pc/pc4
//   pc_i     in   PC of the instruction being captured
//   pc4_i    in   pc_i + 4
//   instr_i  in   instruction word being captured
//   pc_o     out  held PC
//   pc4_o    out  held PC + 4
//   instr_o  out  held instruction (NOP_INSTR when a bubble)
//   valid_o  out  1 when a real instruction is held
//
// Flush wins over load. With neither asserted every field holds.
// ----------------------------------------------------------------------------
module if_id_reg
   import rv32i_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_i,
   input  logic            flush_i,
   input  logic [PC_W-1:0] pc_i,
   input  logic [PC_W-1:0] pc4_i,
   input  logic [31:0]     instr_i,
   output logic [PC_W-1:0] pc_o,
   output logic [PC_W-1:0] pc4_o,
   output logic [31:0]     instr_o,
   output logic            valid_o
);

   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] pc4_q, pc4_d;
   logic [31:0]     instr_q, instr_d;
   logic            valid_q, valid_d;

   always_comb begin
      pc_d    = pc_q;
      pc4_d   = pc4_q;
      instr_d = instr_q;
      valid_d = valid_q;
      if (flush_i) begin
         // Bubble: the PC fields keep their last values on purpose.
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (load_i) begin
         pc_d    = pc_i;
         pc4_d   = pc4_i;
         instr_d = instr_i;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= '0;
         pc4_q   <= '0;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         pc4_q   <= pc4_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign pc_o    = pc_q;
   assign pc4_o   = pc4_q;
   assign instr_o = instr_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: program counter, BOOT/RUN control FSM, saturating
// fetch counter and the IF/ID pipeline register.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   stall        in   hold PC, IF/ID and fetch counter
//   redirect     in   taken branch/jump; wins over stall
//   redirect_pc  in   redirect target byte address (bits [1:0] ignored)
//   imem_addr    out  fetch byte address (the PC register itself)
//   imem_dout    in   instruction word at imem_addr, combinational
//   id_pc        out  PC of the instruction in IF/ID
//   id_pc4       out  id_pc + 4
//   id_instr     out  instruction in IF/ID
//   id_valid     out  IF/ID holds a real instruction
//   fetch_cnt    out  instructions accepted into IF/ID, saturating at FFFF
//   dbg_state    out  FSM state (0 = BOOT, 1 = RUN)
//
// Handshake: there is no valid/ready pair here. An edge in RUN with
// redirect=0 and stall=0 is a fetch (PC advances, IF/ID loads, counter
// counts); redirect=1 flushes IF/ID and reloads the PC regardless of stall;
// stall=1 alone freezes everything. In BOOT both inputs are ignored.
// ----------------------------------------------------------------------------
module if_stage
   import rv32i_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   output logic [PC_W-1:0] imem_addr,
   input  logic [31:0]     imem_dout,
   output logic [PC_W-1:0] id_pc,
   output logic [PC_W-1:0] id_pc4,
   output logic [31:0]     id_instr,
   output logic            id_valid,
   output logic [15:0]     fetch_cnt,
   output logic            dbg_state
);

   fetch_state_e    state_q;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     cnt_q, cnt_d;

   logic in_run;
   logic take_redirect;
   logic take_fetch;

   assign in_run        = (state_q == ST_RUN);
   assign take_redirect = in_run & redirect;
   assign take_fetch    = in_run & ~redirect & ~stall;

   always_comb begin
      pc_d = pc_q;
      if (take_redirect) begin
         pc_d = align_pc(redirect_pc);
      end else if (take_fetch) begin
         pc_d = pc_next(pc_q);
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (take_fetch && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // BOOT lasts exactly one edge; only rst can bring the FSM back to it.
   // While in BOOT, pc_d equals pc_q, so the PC stays at RESET_PC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
      end else begin
         state_q <= ST_RUN;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk     (clk),
      .rst     (rst),
      .load_i  (take_fetch),
      .flush_i (take_redirect),
      .pc_i    (pc_q),
      .pc4_i   (pc_next(pc_q)),
      .instr_i (imem_dout),
      .pc_o    (id_pc),
      .pc4_o   (id_pc4),
      .instr_o (id_instr),
      .valid_o (id_valid)
   );

   assign imem_addr = pc_q;
   assign fetch_cnt = cnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage: directed vector table, hand-written
// reset/boot and saturation sequences, and a randomized run compared against
// a behavioural model of the fetch rules.
// ----------------------------------------------------------------------------
module tb_if_stage;
   import rv32i_pkg::*;

   // ---------------- clock / reset ----------------
   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [19:0] redirect_pc;
   logic [19:0] imem_addr;
   logic [31:0] imem_dout;
   logic [19:0] id_pc;
   logic [19:0] id_pc4;
   logic [31:0] id_instr;
   logic        id_valid;
   logic [15:0] fetch_cnt;
   logic        dbg_state;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   if_stage dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_dout   (imem_dout),
      .id_pc       (id_pc),
      .id_pc4      (id_pc4),
      .id_instr    (id_instr),
      .id_valid    (id_valid),
      .fetch_cnt   (fetch_cnt),
      .dbg_state   (dbg_state)
   );

   // ---------------- instruction memory ----------------
   function automatic logic [31:0] mem_word(input logic [19:0] a);
      if (a == 20'h00000) return 32'h00A00213;
      if (a == 20'h00004) return 32'h00000013;
      return {12'hA5C, a} ^ 32'h0000_1357;
   endfunction

   assign imem_dout = mem_word(imem_addr);

   // ---------------- scoreboard counters ----------------
   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         pass_cnt++;
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [19:0] m_pc;
   bit          m_boot;
   logic [19:0] m_id_pc;
   logic [19:0] m_id_pc4;
   logic [31:0] m_instr;
   logic        m_valid;
   int          m_cnt;

   task automatic model_reset();
      m_pc     = 20'h00000;
      m_boot   = 1'b1;
      m_id_pc  = 20'h0;
      m_id_pc4 = 20'h0;
      m_instr  = 32'h00000013;
      m_valid  = 1'b0;
      m_cnt    = 0;
   endtask

   task automatic model_edge();
      if (m_boot) begin
         m_boot = 1'b0;
      end else if (redirect) begin
         m_pc    = redirect_pc - (redirect_pc % 4);
         m_instr = 32'h00000013;
         m_valid = 1'b0;
      end else if (!stall) begin
         m_id_pc  = m_pc;
         m_id_pc4 = 20'((int'(m_pc) + 4) % (1 << 20));
         m_instr  = mem_word(m_pc);
         m_valid  = 1'b1;
         m_pc     = 20'((int'(m_pc) + 4) % (1 << 20));
         if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".addr"},  32'(imem_addr), 32'(m_pc));
      chk({tag, ".id_pc"}, 32'(id_pc),     32'(m_id_pc));
      chk({tag, ".pc4"},   32'(id_pc4),    32'(m_id_pc4));
      chk({tag, ".instr"}, id_instr,       m_instr);
      chk({tag, ".valid"}, 32'(id_valid),  32'(m_valid));
      chk({tag, ".cnt"},   32'(fetch_cnt), 32'(m_cnt));
      chk({tag, ".state"}, 32'(dbg_state), m_boot ? 32'(ST_BOOT) : 32'(ST_RUN));
   endtask

   // ---------------- driver tasks ----------------
   // One clock edge; outputs are sampled 1 time unit after it.
   task automatic step(input bit do_check, input string tag);
      @(posedge clk);
      if (!rst) model_edge();
      #1;
      if (do_check) check_model(tag);
   endtask

   // Asynchronous reset pulse asserted mid-cycle, held across one edge.
   task automatic pulse_reset(input string tag);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_model({tag, "_async"});
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        stall;
      logic        redirect;
      logic [19:0] rpc;
      logic [19:0] addr;
      logic [19:0] id_pc;
      logic [19:0] id_pc4;
      logic [31:0] instr;
      logic        valid;
      logic [15:0] cnt;
   } vec_t;

   localparam int NVEC = 10;
   vec_t vecs[NVEC];

   function automatic vec_t mk(input logic s, input logic r, input logic [19:0] rpc,
                               input logic [19:0] addr, input logic [19:0] ipc,
                               input logic [19:0] ipc4, input logic [31:0] instr,
                               input logic v, input logic [15:0] cnt);
      vec_t t;
      t.stall = s; t.redirect = r; t.rpc = rpc; t.addr = addr; t.id_pc = ipc;
      t.id_pc4 = ipc4; t.instr = instr; t.valid = v; t.cnt = cnt;
      return t;
   endfunction

   // ---------------- main test ----------------
   initial begin
      // Rows: inputs before the edge, expected outputs after it.
      vecs[0] = mk(0, 0, 20'h0,     20'h00000, 20'h00000, 20'h00000, 32'h00000013,      0, 16'd0); // BOOT edge
      vecs[1] = mk(0, 0, 20'h0,     20'h00004, 20'h00000, 20'h00004, 32'h00A00213,      1, 16'd1);
      vecs[2] = mk(0, 0, 20'h0,     20'h00008, 20'h00004, 20'h00008, 32'h00000013,      1, 16'd2);
      vecs[3] = mk(1, 0, 20'h0,     20'h00008, 20'h00004, 20'h00008, 32'h00000013,      1, 16'd2);
      vecs[4] = mk(1, 0, 20'h0,     20'h00008, 20'h00004, 20'h00008, 32'h00000013,      1, 16'd2);
      vecs[5] = mk(1, 0, 20'h0,     20'h00008, 20'h00004, 20'h00008, 32'h00000013,      1, 16'd2);
      vecs[6] = mk(0, 0, 20'h0,     20'h0000C, 20'h00008, 20'h0000C, mem_word(20'h8),   1, 16'd3);
      vecs[7] = mk(1, 1, 20'h00043, 20'h00040, 20'h00008, 20'h0000C, 32'h00000013,      0, 16'd3);
      vecs[8] = mk(0, 1, 20'hFFFFF, 20'hFFFFC, 20'h00008, 20'h0000C, 32'h00000013,      0, 16'd3);
      vecs[9] = mk(0, 0, 20'h0,     20'h00000, 20'hFFFFC, 20'h00000, mem_word(20'hFFFFC), 1, 16'd4);

      rst = 1'b1;
      stall = 1'b0;
      redirect = 1'b0;
      redirect_pc = 20'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst.addr",  32'(imem_addr), 32'h00000);
      chk("rst.id_pc", 32'(id_pc),     32'h0);
      chk("rst.pc4",   32'(id_pc4),    32'h0);
      chk("rst.instr", id_instr,       32'h00000013);
      chk("rst.valid", 32'(id_valid),  32'h0);
      chk("rst.cnt",   32'(fetch_cnt), 32'h0);
      chk("rst.state", 32'(dbg_state), 32'(ST_BOOT));
      rst = 1'b0;

      // Directed table
      for (int i = 0; i < NVEC; i++) begin
         stall       = vecs[i].stall;
         redirect    = vecs[i].redirect;
         redirect_pc = vecs[i].rpc;
         step(1'b0, "");
         chk($sformatf("vec%0d.addr", i),  32'(imem_addr), 32'(vecs[i].addr));
         chk($sformatf("vec%0d.id_pc", i), 32'(id_pc),     32'(vecs[i].id_pc));
         chk($sformatf("vec%0d.pc4", i),   32'(id_pc4),    32'(vecs[i].id_pc4));
         chk($sformatf("vec%0d.instr", i), id_instr,       vecs[i].instr);
         chk($sformatf("vec%0d.valid", i), 32'(id_valid),  32'(vecs[i].valid));
         chk($sformatf("vec%0d.cnt", i),   32'(fetch_cnt), 32'(vecs[i].cnt));
      end
      stall = 1'b0;
      redirect = 1'b0;
      check_model("after_table");

      // Advance to pc = 0x10, then assert reset between edges.
      for (int i = 0; i < 4; i++) step(1'b1, "to_pc10");
      chk("pc_is_10", 32'(imem_addr), 32'h10);
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      chk("async.addr",  32'(imem_addr), 32'h0);
      chk("async.instr", id_instr,       32'h00000013);
      chk("async.valid", 32'(id_valid),  32'h0);
      chk("async.cnt",   32'(fetch_cnt), 32'h0);
      chk("async.state", 32'(dbg_state), 32'(ST_BOOT));
      // Reset held across an edge with stall/redirect active.
      stall = 1'b1;
      redirect = 1'b1;
      redirect_pc = 20'h00080;
      step(1'b1, "rst_held");
      rst = 1'b0;
      // BOOT ignores both stall and redirect.
      step(1'b1, "boot_ignores");
      chk("boot.addr", 32'(imem_addr), 32'h0);
      stall = 1'b0;
      redirect = 1'b0;
      step(1'b1, "first_fetch");
      chk("first.instr", id_instr, 32'h00A00213);

      // Randomized run against the model
      for (int i = 0; i < 1500; i++) begin
         stall       = ($urandom_range(0, 99) < 30);
         redirect    = ($urandom_range(0, 99) < 10);
         redirect_pc = 20'($urandom_range(0, 20'hFFFFF));
         step(1'b1, "rand");
         if ($urandom_range(0, 99) == 0) pulse_reset("rand_rst");
      end

      // Saturation: one BOOT edge plus 0xFFFE fetches.
      stall = 1'b0;
      redirect = 1'b0;
      pulse_reset("sat");
      repeat (65535) step(1'b0, "");
      chk("sat.fffe", 32'(fetch_cnt), 32'h0000FFFE);
      step(1'b1, "sat1");
      chk("sat.ffff_1", 32'(fetch_cnt), 32'h0000FFFF);
      step(1'b1, "sat2");
      chk("sat.ffff_2", 32'(fetch_cnt), 32'h0000FFFF);
      step(1'b1, "sat3");
      chk("sat.ffff_3", 32'(fetch_cnt), 32'h0000FFFF);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
